// File: rtl/muldiv_iterativo_if.sv
// Handshake and result bundle between the issue logic and the iterative
// RV32M multiply/divide unit.
interface muldiv_iterativo_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] readdata1R;
    logic [31:0] readdata2R;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic        regiwrite;
    logic [31:0] aluresult2;
    logic [4:0]  rd_out;

    modport master (
        output start, funct3, readdata1R, readdata2R, rd,
        input  busy, done, regiwrite, aluresult2, rd_out
    );

    modport slave (
        input  start, funct3, readdata1R, readdata2R, rd,
        output busy, done, regiwrite, aluresult2, rd_out
    );
endinterface

// File: rtl/muldiv_iterativo.sv
// Iterative RV32M multiply/divide unit: radix-2, one bit per cycle, 32
// iterations. Optional macro MULDIV_EARLY_OUT_EN lets divide-by-zero and
// signed-overflow operands skip the iteration loop (latency 1 instead of 32).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; operands latched on start
// ST_CALC  | 32 shift-add / restoring-divide iterations
// ST_DONE  | result registered; done pulses for this one cycle
module muldiv_iterativo (
    input  logic               clk,
    input  logic               rst_n,
    muldiv_iterativo_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [2:0]  f3;
    logic [4:0]  rd_q;
    logic [31:0] res_q;
    logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd;      // mul: multiplicand magnitude; div: divisor magnitude
    logic        neg_res;
    logic        spec_hit;
    logic [31:0] spec_res;

    logic        is_div_in, a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [31:0] a_mag, b_mag;
    logic        div_zero_in, ovf_in, spec_in;
    logic [31:0] spec_val_in;

    // Operand decode at issue time: magnitudes, result sign and special cases
    always_comb begin
        is_div_in   = bus.funct3[2];
        a_signed    = is_div_in ? ~bus.funct3[0] : (bus.funct3 != 3'b011);
        b_signed    = is_div_in ? ~bus.funct3[0] : ~bus.funct3[1];
        a_neg       = a_signed & bus.readdata1R[31];
        b_neg       = b_signed & bus.readdata2R[31];
        a_mag       = a_neg ? (~bus.readdata1R + 32'd1) : bus.readdata1R;
        b_mag       = b_neg ? (~bus.readdata2R + 32'd1) : bus.readdata2R;
        // remainder follows the dividend; everything else follows the xor
        neg_in      = (is_div_in && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero_in = is_div_in && (bus.readdata2R == 32'd0);
        ovf_in      = is_div_in && !bus.funct3[0] &&
                      (bus.readdata1R == 32'h8000_0000) && (bus.readdata2R == 32'hFFFF_FFFF);
        spec_in     = div_zero_in | ovf_in;
        spec_val_in = 32'd0;
        if (div_zero_in)
            spec_val_in = bus.funct3[1] ? bus.readdata1R : 32'hFFFF_FFFF;
        else if (ovf_in)
            spec_val_in = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_trial;
    logic [63:0] acc_next, prod;
    logic [31:0] quo_fix, rem_fix, result_sel;

    // One iteration step plus the sign-corrected result selection
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
        div_shift = {acc[63:32], acc[31]};
        div_trial = div_shift - {1'b0, opnd};
        if (f3[2]) begin
            if (!div_trial[32])
                acc_next = {div_trial[31:0], acc[30:0], 1'b1};
            else
                acc_next = {div_shift[31:0], acc[30:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[31:1]};
        end
        prod    = neg_res ? (~acc_next + 64'd1) : acc_next;
        quo_fix = neg_res ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
        rem_fix = neg_res ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
        case (f3)
            3'b000:          result_sel = prod[31:0];
            3'b100, 3'b101:  result_sel = quo_fix;
            3'b110, 3'b111:  result_sel = rem_fix;
            default:         result_sel = prod[63:32];
        endcase
        if (spec_hit)
            result_sel = spec_res;
    end

    // Sequencer: issue, iterate, publish, and abandon everything on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= 6'd0;
            f3       <= 3'd0;
            rd_q     <= 5'd0;
            res_q    <= 32'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            neg_res  <= 1'b0;
            spec_hit <= 1'b0;
            spec_res <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        f3       <= bus.funct3;
                        rd_q     <= bus.rd;
                        neg_res  <= neg_in;
                        spec_hit <= spec_in;
                        spec_res <= spec_val_in;
                        cnt      <= 6'd0;
                        opnd     <= is_div_in ? b_mag : a_mag;
                        acc      <= {32'd0, (is_div_in ? a_mag : b_mag)};
`ifdef MULDIV_EARLY_OUT_EN
                        if (spec_in) begin
                            res_q <= spec_val_in;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
`else
                        state    <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        res_q <= result_sel;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.regiwrite  = (state == ST_DONE) && (rd_q != 5'd0);
    assign bus.aluresult2 = res_q;
    assign bus.rd_out     = rd_q;
endmodule
